// File: rtl/fifo_ram_port_if.sv
// Board/controller-side bundle for fifo_ram_port: key, data switches, FIFO flags and results.
// par_err exists only when FIFO_RAM_PARITY_EN is defined.
interface fifo_ram_port_if #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 3
);
   logic                  key_raw;
   logic                  rw;
   logic [WIDTH-1:0]      din;
   logic [DEPTH_LOG2-1:0] addr;
   logic                  full;
   logic                  empty;
   logic                  key_pulse;
   logic                  busy;
   logic [WIDTH-1:0]      dout;
   logic                  dout_valid;
   logic                  wr_done;
   logic                  err_ovf;
   logic                  err_unf;
`ifdef FIFO_RAM_PARITY_EN
   logic                  par_err;
`endif

   modport master (
      output key_raw, rw, din, addr, full, empty,
      input  key_pulse, busy, dout, dout_valid, wr_done, err_ovf, err_unf
`ifdef FIFO_RAM_PARITY_EN
      , input par_err
`endif
   );

   modport slave (
      input  key_raw, rw, din, addr, full, empty,
      output key_pulse, busy, dout, dout_valid, wr_done, err_ovf, err_unf
`ifdef FIFO_RAM_PARITY_EN
      , output par_err
`endif
   );
endinterface

// File: rtl/fifo_ram_port.sv
// Data-side responder for the FIFO address controller: key debounce, RAM storage, read/write FSM.
// Optional FIFO_RAM_PARITY_EN: stores an even-parity bit per entry and flags mismatches on read.
module fifo_ram_port #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 3,
   parameter int DEB_CYCLES = 4
) (
   input logic              clk,
   input logic              rst_n,
   fifo_ram_port_if.slave   bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CNT_W = $clog2(DEB_CYCLES + 1);
`ifdef FIFO_RAM_PARITY_EN
   localparam int MEM_W = WIDTH + 1;
`else
   localparam int MEM_W = WIDTH;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, ACCESS = 2'd2, DONE = 2'd3} state_t;

   logic [1:0]       sync_q;
   logic             stable_q;
   logic [CNT_W-1:0] deb_cnt;
   logic             key_s;
   logic             key_flip;
   logic             key_rise;
   logic             key_pulse_q;

   state_t           state_q;
   logic             op_q;
   logic [WIDTH-1:0] dout_q;
   logic             dout_valid_q;
   logic             wr_done_q;
   logic             err_ovf_q;
   logic             err_unf_q;
`ifdef FIFO_RAM_PARITY_EN
   logic             par_err_q;
`endif

   logic [WIDTH-1:0] wdata_q;
   logic [MEM_W-1:0] rdata_q;
   logic [MEM_W-1:0] mem [DEPTH];

   assign key_s    = sync_q[1];
   assign key_flip = (key_s != stable_q) && (deb_cnt == CNT_W'(DEB_CYCLES - 1));
   // The FSM reacts on the same edge that raises key_pulse, so CHECK lines up with the strobe.
   assign key_rise = key_flip && key_s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= 2'b00;
         stable_q    <= 1'b0;
         deb_cnt     <= '0;
         key_pulse_q <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], bus.key_raw};
         key_pulse_q <= key_rise;
         if (key_s == stable_q) begin
            deb_cnt <= '0;
         end else if (key_flip) begin
            stable_q <= key_s;
            deb_cnt  <= '0;
         end else begin
            deb_cnt <= deb_cnt + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         op_q         <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         wr_done_q    <= 1'b0;
         err_ovf_q    <= 1'b0;
         err_unf_q    <= 1'b0;
`ifdef FIFO_RAM_PARITY_EN
         par_err_q    <= 1'b0;
`endif
      end else begin
         dout_valid_q <= 1'b0;
         wr_done_q    <= 1'b0;
         err_ovf_q    <= 1'b0;
         err_unf_q    <= 1'b0;
`ifdef FIFO_RAM_PARITY_EN
         par_err_q    <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (key_rise) begin
                  op_q    <= bus.rw;
                  state_q <= CHECK;
               end
            end
            CHECK: begin
               // With full and empty both set, each direction is rejected on its own flag.
               if (op_q && bus.full) begin
                  err_ovf_q <= 1'b1;
                  state_q   <= IDLE;
               end else if (!op_q && bus.empty) begin
                  err_unf_q <= 1'b1;
                  state_q   <= IDLE;
               end else begin
                  state_q <= ACCESS;
               end
            end
            ACCESS: state_q <= DONE;
            DONE: begin
               if (op_q) begin
                  wr_done_q <= 1'b1;
               end else begin
                  dout_q       <= rdata_q[WIDTH-1:0];
                  dout_valid_q <= 1'b1;
`ifdef FIFO_RAM_PARITY_EN
                  par_err_q    <= (^rdata_q[WIDTH-1:0]) != rdata_q[WIDTH];
`endif
               end
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Storage and data latches carry no reset; an abort is safe because state_q leaves ACCESS at once.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && key_rise) begin
         wdata_q <= bus.din;
      end
      if (state_q == ACCESS) begin
         if (op_q) begin
`ifdef FIFO_RAM_PARITY_EN
            mem[bus.addr] <= {^wdata_q, wdata_q};
`else
            mem[bus.addr] <= wdata_q;
`endif
         end else begin
            rdata_q <= mem[bus.addr];
         end
      end
   end

   assign bus.key_pulse  = key_pulse_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.wr_done    = wr_done_q;
   assign bus.err_ovf    = err_ovf_q;
   assign bus.err_unf    = err_unf_q;
`ifdef FIFO_RAM_PARITY_EN
   assign bus.par_err    = par_err_q;
`endif
endmodule

// File: tb/tb_fifo_ram_port.sv
// Scoreboard bench for fifo_ram_port: stimulus queues expected result pulses, a monitor pops them.
// A second instance with DEB_CYCLES=1 lets two presses land inside one busy window.
`timescale 1ns/1ps
module tb_fifo_ram_port;
   localparam int W = 8;
   localparam int A = 3;
   localparam int K_WR = 0, K_RD = 1, K_OVF = 2, K_UNF = 3;

   typedef struct {
      int         kind;
      logic [W-1:0] data;
      int         cyc;
      logic       par;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_ram_port_if #(.WIDTH(W), .DEPTH_LOG2(A)) bus ();
   fifo_ram_port_if #(.WIDTH(W), .DEPTH_LOG2(A)) fbus ();

   fifo_ram_port #(.WIDTH(W), .DEPTH_LOG2(A), .DEB_CYCLES(4)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   fifo_ram_port #(.WIDTH(W), .DEPTH_LOG2(A), .DEB_CYCLES(1)) dut_fast (
      .clk(clk), .rst_n(rst_n), .bus(fbus)
   );

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   kp_cnt = 0;
   int   fkp_cnt = 0;
   int   fres_cnt = 0;
   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every result pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         logic [3:0] act;
         logic [3:0] exv;
         exp_t e;
         if (bus.key_pulse) kp_cnt++;
         if (fbus.key_pulse) fkp_cnt++;
         if (fbus.wr_done | fbus.dout_valid | fbus.err_ovf | fbus.err_unf) fres_cnt++;
         act = {bus.wr_done, bus.dout_valid, bus.err_ovf, bus.err_unf};
         if (act != 4'b0000) begin
            if (sb.size() == 0) begin
               check("unexpected_pulse", {28'd0, act}, 32'd0);
            end else begin
               e = sb.pop_front();
               exv = 4'b1000 >> e.kind;
               check("pulse_kind", {28'd0, act}, {28'd0, exv});
               check("pulse_cycle", cyc, e.cyc);
               if (e.kind == K_RD) check("rd_data", {24'd0, bus.dout}, {24'd0, e.data});
`ifdef FIFO_RAM_PARITY_EN
               check("par_err", {31'd0, bus.par_err}, {31'd0, e.par});
`endif
            end
         end
      end
   end

   task automatic wait_pulse(output logic got, output int kc);
      got = 1'b0;
      kc = 0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         if (bus.key_pulse) begin
            got = 1'b1;
            kc = cyc;
         end
      end
   endtask

   task automatic push_exp(input int kind, input logic [W-1:0] data, input int kc, input logic par);
      exp_t e;
      e.kind = kind;
      e.data = data;
      e.cyc  = kc + ((kind == K_WR || kind == K_RD) ? 3 : 1);
      e.par  = par;
      sb.push_back(e);
   endtask

   task automatic press(input logic rw, input logic [W-1:0] din, input logic [A-1:0] addr,
                        input logic full, input logic empty, input int kind,
                        input logic [W-1:0] data, input logic par);
      logic got;
      int   kc;
      bus.rw = rw; bus.din = din; bus.addr = addr; bus.full = full; bus.empty = empty;
      bus.key_raw = 1'b1;
      wait_pulse(got, kc);
      check("press_key_pulse", {31'd0, got}, 32'd1);
      if (got) push_exp(kind, data, kc, par);
      bus.key_raw = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic got;
      int   kc;
      int   r;
      int   kp0;
      bus.key_raw = 1'b0; bus.rw = 1'b0; bus.din = '0; bus.addr = '0;
      bus.full = 1'b0; bus.empty = 1'b0;
      fbus.key_raw = 1'b0; fbus.rw = 1'b1; fbus.din = 8'h5A; fbus.addr = 3'd7;
      fbus.full = 1'b0; fbus.empty = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {18'd0, bus.key_pulse, bus.busy, bus.dout, bus.dout_valid,
                              bus.wr_done, bus.err_ovf, bus.err_unf}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Bounce: 2-cycle glitches, then a held press that writes A5 to addr 3.
      bus.rw = 1'b1; bus.din = 8'hA5; bus.addr = 3'd3; bus.full = 1'b0; bus.empty = 1'b0;
      kp0 = kp_cnt;
      bus.key_raw = 1'b1; repeat (2) @(negedge clk);
      bus.key_raw = 1'b0; repeat (2) @(negedge clk);
      bus.key_raw = 1'b1; repeat (2) @(negedge clk);
      bus.key_raw = 1'b0; repeat (2) @(negedge clk);
      bus.key_raw = 1'b1;
      r = cyc;
      wait_pulse(got, kc);
      check("bounce_pulse_seen", {31'd0, got}, 32'd1);
      check("bounce_pulse_cycle", kc, r + 4 + 2);
      if (got) push_exp(K_WR, 8'h00, kc, 1'b0);
      repeat (10 - (kc - r)) @(negedge clk);
      bus.key_raw = 1'b0;
      repeat (12) @(negedge clk);
      check("bounce_pulse_count", kp_cnt - kp0, 1);

      press(1'b0, 8'h00, 3'd3, 1'b0, 1'b0, K_RD, 8'hA5, 1'b0);
      press(1'b1, 8'h3C, 3'd6, 1'b0, 1'b0, K_WR, 8'h00, 1'b0);
      press(1'b0, 8'h00, 3'd6, 1'b0, 1'b0, K_RD, 8'h3C, 1'b0);

      // Rejections leave storage and dout untouched.
      press(1'b1, 8'hFF, 3'd3, 1'b1, 1'b0, K_OVF, 8'h00, 1'b0);
      press(1'b0, 8'h00, 3'd3, 1'b0, 1'b0, K_RD, 8'hA5, 1'b0);
      press(1'b0, 8'h00, 3'd6, 1'b0, 1'b1, K_UNF, 8'h00, 1'b0);
      check("dout_held_after_unf", {24'd0, bus.dout}, 32'h0000_00A5);
      press(1'b1, 8'h77, 3'd6, 1'b1, 1'b1, K_OVF, 8'h00, 1'b0);
      press(1'b0, 8'h00, 3'd6, 1'b1, 1'b1, K_UNF, 8'h00, 1'b0);
      press(1'b0, 8'h00, 3'd6, 1'b0, 1'b0, K_RD, 8'h3C, 1'b0);

      // Async reset during ACCESS of a write: 11 stays in addr 5.
      press(1'b1, 8'h11, 3'd5, 1'b0, 1'b0, K_WR, 8'h00, 1'b0);
      bus.rw = 1'b1; bus.din = 8'h22; bus.addr = 3'd5; bus.full = 1'b0; bus.empty = 1'b0;
      bus.key_raw = 1'b1;
      wait_pulse(got, kc);
      check("abort_key_pulse", {31'd0, got}, 32'd1);
      @(negedge clk);
      check("abort_in_access_busy", {31'd0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      bus.key_raw = 1'b0;
      #1;
      check("abort_outputs_zero", {18'd0, bus.key_pulse, bus.busy, bus.dout, bus.dout_valid,
                                   bus.wr_done, bus.err_ovf, bus.err_unf}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_idle_after_release", {31'd0, bus.busy}, 32'd0);
      press(1'b0, 8'h00, 3'd5, 1'b0, 1'b0, K_RD, 8'h11, 1'b0);

`ifdef FIFO_RAM_PARITY_EN
      press(1'b1, 8'h01, 3'd1, 1'b0, 1'b0, K_WR, 8'h00, 1'b0);
      dut.mem[1][W] = ~dut.mem[1][W];
      press(1'b0, 8'h00, 3'd1, 1'b0, 1'b0, K_RD, 8'h01, 1'b1);
      press(1'b1, 8'h03, 3'd2, 1'b0, 1'b0, K_WR, 8'h00, 1'b0);
      press(1'b0, 8'h00, 3'd2, 1'b0, 1'b0, K_RD, 8'h03, 1'b0);
`endif

      // Lockout: fast instance gets two strobes 2 cycles apart, only one operation runs.
      fkp_cnt = 0;
      fres_cnt = 0;
      fbus.key_raw = 1'b1; @(negedge clk);
      fbus.key_raw = 1'b0; @(negedge clk);
      fbus.key_raw = 1'b1; @(negedge clk);
      fbus.key_raw = 1'b0;
      repeat (12) @(negedge clk);
      check("lockout_key_pulses", fkp_cnt, 2);
      check("lockout_results", fres_cnt, 1);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
